// File: rtl/irom_boot_loader.sv
// irom_boot_loader: receives a byte stream (word count, data words, checksum),
// writes the image into instruction memory and releases the CPU from reset
// once the XOR checksum of all data words matches.
module irom_boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst_n,
    output logic                  boot_done,
    output logic                  boot_err
);

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    state_t                state;
    logic [1:0]            byte_idx;
    logic [23:0]           byte_buf;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH:0]   n_words;
    logic [31:0]           checksum;
    logic [TW-1:0]         idle_cnt;
    logic                  started;

    logic                  accept;
    logic                  word_full;
    logic [31:0]           word;
    logic [ADDR_WIDTH:0]   cnt_next;
    logic                  active;
    logic                  idle_expired;

    // Byte handshake, word assembly view and timeout detection
    always_comb begin
        accept       = rx_valid && rx_ready;
        word_full    = accept && (byte_idx == 2'd3);
        word         = {rx_data, byte_buf};
        cnt_next     = word_cnt + 1'b1;
        active       = (state == HDR) || (state == DATA) || (state == CSUM);
        idle_expired = started && active && !accept && (idle_cnt == TW'(TIMEOUT - 1));
    end

    // Loader state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HDR;
            byte_idx  <= '0;
            byte_buf  <= '0;
            word_cnt  <= '0;
            n_words   <= '0;
            checksum  <= '0;
            idle_cnt  <= '0;
            started   <= 1'b0;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (accept) begin
                byte_idx <= byte_idx + 1'b1;
                started  <= 1'b1;
                idle_cnt <= '0;
                case (byte_idx)
                    2'd0:    byte_buf[7:0]   <= rx_data;
                    2'd1:    byte_buf[15:8]  <= rx_data;
                    2'd2:    byte_buf[23:16] <= rx_data;
                    default: ;
                endcase
            end else if (started && active) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            case (state)
                HDR: begin
                    rx_ready <= 1'b1;
                    if (word_full) begin
                        if ({1'b0, word} > MAX_WORDS) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            boot_err <= 1'b1;
                        end else if (word == '0) begin
                            state <= CSUM;
                        end else begin
                            n_words <= word[ADDR_WIDTH:0];
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    rx_ready <= 1'b1;
                    if (word_full) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                        mem_wdata <= word;
                        checksum  <= checksum ^ word;
                        word_cnt  <= cnt_next;
                        if (cnt_next == n_words)
                            state <= CSUM;
                    end
                end
                CSUM: begin
                    rx_ready <= 1'b1;
                    if (word_full) begin
                        rx_ready <= 1'b0;
                        if (word == checksum) begin
                            state     <= DONE;
                            cpu_rst_n <= 1'b1;
                            boot_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            boot_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    rx_ready  <= 1'b0;
                    cpu_rst_n <= 1'b1;
                    boot_done <= 1'b1;
                end
                default: begin
                    rx_ready  <= 1'b0;
                    cpu_rst_n <= 1'b0;
                    boot_err  <= 1'b1;
                end
            endcase

            // Timeout only fires on a cycle with no accepted byte, so it never
            // collides with a word completion above.
            if (idle_expired) begin
                state    <= ERR;
                rx_ready <= 1'b0;
                boot_err <= 1'b1;
            end
        end
    end

endmodule
